dddr_responder: RTL

Data-side memory responder: the slave end of the dddr request/response interface driven by the pipeline memory stage.
- Accepts level-held read/write requests, waits a fixed latency, then performs a byte/half/word access to an on-chip word array and pulses dddr_resp for one cycle.
- Read data is returned right-justified (addressed byte in [7:0]); the memory stage zero-extends it to the access width.

---
 rtl/dddr_responder_pkg.sv | 40 ++++
 rtl/dddr_responder_ram.sv | 30 +++
 rtl/dddr_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dddr_responder_pkg.sv
// Shared types and defaults for the dddr data-side responder.
package dddr_responder_pkg;

    localparam int unsigned DDDR_DEPTH   = 1024;
    localparam int unsigned DDDR_LATENCY = 2;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned LANES        = WORD_W / 8;

    typedef logic [WORD_W-1:0] rvga_word;

    typedef enum logic [1:0] {
        RVGA_BWIDTH = 2'b00,
        RVGA_HWIDTH = 2'b01,
        RVGA_WWIDTH = 2'b10
    } rvga_dwidth;

    typedef enum logic [1:0] {
        DDDR_IDLE = 2'b00,
        DDDR_BUSY = 2'b01,
        DDDR_RESP = 2'b10
    } dddr_state_t;

    typedef struct packed {
        rvga_word   addr;
        rvga_word   wdata;
        logic [1:0] width;
        logic       read;
        logic       write;
    } dddr_req_t;

    // Byte-lane enables for an access of the given width at lane offset off.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            RVGA_BWIDTH: lane_mask = 4'b0001 << off;
            RVGA_HWIDTH: lane_mask = 4'b0011 << {off[1], 1'b0};
            default:     lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dddr_responder_ram.sv
// DEPTH x 32 word array with per-byte write enables.
// Read data is combinational from the array, so a value registered on a write
// edge is the pre-write word (read-before-write).
module dddr_responder_ram
    import dddr_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DDDR_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] we,
    input  rvga_word         wdata,
    output rvga_word         rdata_c
);

    rvga_word mem [DEPTH];

    assign rdata_c = mem[addr];

    // Byte-lane synchronous write
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dddr_responder.sv
// Data-side memory responder: accepts level-held dddr requests, waits a fixed
// latency, performs a byte/half/word access and pulses dddr_resp.
// Optional feature macro: DDDR_ALIGN_CHECK_EN (adds dddr_err for misaligned accesses).
module dddr_responder
    import dddr_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DDDR_DEPTH,
    parameter int unsigned LATENCY = DDDR_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dddr_addr,
    input  logic        dddr_read,
    input  logic        dddr_write,
    input  logic [31:0] dddr_wdata,
    input  logic [1:0]  dddr_width,
    output logic [31:0] dddr_rdata,
    output logic        dddr_resp,
    output logic        dddr_busy
`ifdef DDDR_ALIGN_CHECK_EN
    ,
    output logic        dddr_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    dddr_state_t      state, state_next;
    logic [CW-1:0]    count, count_next;
    dddr_req_t        req_q, req_c;
    logic             latch_c;
    logic             access_c;
    logic             misalign_c;
    logic [1:0]       off_c;
    logic [LANES-1:0] mem_we_c;
    rvga_word         wlane_c;
    rvga_word         mem_rd_c;
    logic             unused_c;

    assign unused_c = ^req_c.addr[31:AW+2];

    // Live inputs while accepting (covers LATENCY==1), latched copy afterwards
    always_comb begin
        req_c = req_q;
        if (state == DDDR_IDLE) begin
            req_c.addr  = dddr_addr;
            req_c.wdata = dddr_wdata;
            req_c.width = dddr_width;
            req_c.read  = dddr_read;
            req_c.write = dddr_write;
        end
    end

    // Alignment, effective lane offset and store-data replication
    always_comb begin
        misalign_c = 1'b0;
        off_c      = req_c.addr[1:0];
        wlane_c    = req_c.wdata;
        case (req_c.width)
            RVGA_BWIDTH: begin
                wlane_c = {4{req_c.wdata[7:0]}};
            end
            RVGA_HWIDTH: begin
`ifdef DDDR_ALIGN_CHECK_EN
                misalign_c = req_c.addr[0];
`endif
                off_c   = {req_c.addr[1], 1'b0};
                wlane_c = {2{req_c.wdata[15:0]}};
            end
            default: begin
`ifdef DDDR_ALIGN_CHECK_EN
                misalign_c = |req_c.addr[1:0];
`endif
                off_c = 2'b00;
            end
        endcase
        mem_we_c = '0;
        if (access_c && rst_n && req_c.write && !misalign_c) begin
            mem_we_c = lane_mask(req_c.width, off_c);
        end
    end

    // Next-state and latency counter
    always_comb begin
        state_next = state;
        count_next = count;
        latch_c    = 1'b0;
        access_c   = 1'b0;
        case (state)
            DDDR_IDLE: begin
                if (dddr_read || dddr_write) begin
                    latch_c = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = DDDR_RESP;
                        access_c   = 1'b1;
                    end else begin
                        state_next = DDDR_BUSY;
                        count_next = CW'(LATENCY - 1);
                    end
                end
            end
            DDDR_BUSY: begin
                count_next = count - CW'(1);
                if (count == CW'(1)) begin
                    state_next = DDDR_RESP;
                    access_c   = 1'b1;
                end
            end
            DDDR_RESP: begin
                state_next = DDDR_IDLE;
            end
            default: begin
                state_next = DDDR_IDLE;
            end
        endcase
    end

    dddr_responder_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .addr    (req_c.addr[AW+1:2]),
        .we      (mem_we_c),
        .wdata   (wlane_c),
        .rdata_c (mem_rd_c)
    );

    // State, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DDDR_IDLE;
            count      <= '0;
            req_q      <= '0;
            dddr_resp  <= 1'b0;
            dddr_busy  <= 1'b0;
            dddr_rdata <= '0;
`ifdef DDDR_ALIGN_CHECK_EN
            dddr_err   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            count     <= count_next;
            dddr_resp <= (state_next == DDDR_RESP);
            dddr_busy <= (state_next != DDDR_IDLE);
            if (latch_c) begin
                req_q <= req_c;
            end
            if (access_c) begin
                if (misalign_c) begin
                    dddr_rdata <= '0;
                end else if (req_c.read) begin
                    dddr_rdata <= mem_rd_c >> {off_c, 3'b000};
                end
            end
`ifdef DDDR_ALIGN_CHECK_EN
            dddr_err <= access_c && misalign_c;
`endif
        end
    end

endmodule
